// File: rtl/prbs_word_engine.sv
// PRBS word engine: a PRBS7/11/15/31 word generator on a valid/ready stream plus
// an independent self-synchronising checker that counts bit and word errors.
module prbs_word_engine #(
    parameter int DATA_W     = 8,
    parameter int LOCK_WORDS = 4,
    parameter int LOSS_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       burst_words,
    input  logic              inject_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              clr_cnt,
    output logic              rx_locked,
    output logic [CNT_W-1:0]  err_bits,
    output logic [CNT_W-1:0]  err_words
);

    localparam int PW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(LOCK_WORDS + 1);
    localparam int BW = $clog2(LOSS_WORDS + 1);

    // The LFSR lives in a 31-bit register; shorter polynomials use the low L bits.
    function automatic logic lfsr_msb(input logic [30:0] s, input logic [1:0] m);
        case (m)
            2'd0:    return s[6];
            2'd1:    return s[10];
            2'd2:    return s[14];
            default: return s[30];
        endcase
    endfunction

    function automatic logic lfsr_fb(input logic [30:0] s, input logic [1:0] m);
        case (m)
            2'd0:    return s[6] ^ s[5];
            2'd1:    return s[10] ^ s[8];
            2'd2:    return s[14] ^ s[13];
            default: return s[30] ^ s[27];
        endcase
    endfunction

    function automatic logic [30:0] lfsr_shift(input logic [30:0] s, input logic [1:0] m,
                                               input logic b);
        case (m)
            2'd0:    return {24'd0, s[5:0], b};
            2'd1:    return {20'd0, s[9:0], b};
            2'd2:    return {16'd0, s[13:0], b};
            default: return {s[29:0], b};
        endcase
    endfunction

    // ---------------- generator ----------------
    logic [30:0]       lfsr_q, lfsr_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       burst_q, burst_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d, gen_w;
    logic [30:0]       gen_nxt;
    logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d, inj_q, inj_d;
    logic              start_go, hs, last_w, inj_hit;

    assign start_go = start & ~stop & ~busy_q;
    assign hs       = valid_q & tx_ready;
    assign last_w   = (burst_q != 16'd0) && (cnt_q + 16'd1 == burst_q);
    assign inj_hit  = inj_q | inject_err;

    // Unroll DATA_W LFSR steps: from the all-ones seed on start, else from the live state.
    always_comb begin
        logic [30:0] s;
        logic [1:0]  m;
        m     = start_go ? mode : mode_q;
        s     = start_go ? '1 : lfsr_q;
        gen_w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            gen_w[i] = lfsr_msb(s, m);
            s        = lfsr_shift(s, m, lfsr_fb(s, m));
        end
        gen_nxt = s;
    end

    // Burst control. The word already on the bus is committed, so an inject flag
    // lands on the next word placed on the bus; the LFSR itself never sees it.
    always_comb begin
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        inj_d   = inj_hit;
        if (start_go) begin
            mode_d  = mode;
            burst_d = burst_words;
            cnt_d   = 16'd0;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            lfsr_d  = gen_nxt;
            data_d  = gen_w ^ DATA_W'(inj_hit);
            inj_d   = 1'b0;
        end else if (busy_q) begin
            if (hs) cnt_d = cnt_q + 16'd1;
            if (stop || (hs && last_w)) begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                inj_d   = 1'b0;
            end else if (hs) begin
                lfsr_d = gen_nxt;
                data_d = gen_w ^ DATA_W'(inj_hit);
                inj_d  = 1'b0;
            end
        end
    end

    // Generator state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lfsr_q  <= '1;
            mode_q  <= 2'd0;
            burst_q <= 16'd0;
            cnt_q   <= 16'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inj_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inj_q   <= inj_d;
        end
    end

    // ---------------- checker ----------------
    logic [30:0]       hist_q, hist_d, chk_nxt;
    logic [DATA_W-1:0] mis;
    logic [PW-1:0]     pop;
    logic [1:0]        mprev_q, mprev_d;
    logic [GW-1:0]     good_q, good_d;
    logic [BW-1:0]     bad_q, bad_d;
    logic              lock_q, lock_d;
    logic [CNT_W-1:0]  ebits_q, ebits_d, ewords_q, ewords_d;
    logic [CNT_W:0]    bsum, wsum;

    // Predict each bit from history; HUNT learns from received bits, LOCKED free-runs.
    always_comb begin
        logic [30:0] h;
        logic        e;
        h   = hist_q;
        mis = '0;
        pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            e      = lfsr_fb(h, mode);
            mis[i] = rx_data[i] ^ e;
            pop    = pop + PW'(mis[i]);
            h      = lfsr_shift(h, mode, lock_q ? e : rx_data[i]);
        end
        chk_nxt = h;
    end

    assign bsum = {1'b0, ebits_q} + (CNT_W + 1)'(pop);
    assign wsum = {1'b0, ewords_q} + (CNT_W + 1)'(1);

    // Lock/loss FSM and saturating error counters; clr_cnt overrides any increment.
    always_comb begin
        hist_d   = hist_q;
        mprev_d  = mode;
        good_d   = good_q;
        bad_d    = bad_q;
        lock_d   = lock_q;
        ebits_d  = ebits_q;
        ewords_d = ewords_q;
        if (mode != mprev_q) begin
            lock_d   = 1'b0;
            good_d   = '0;
            bad_d    = '0;
            ebits_d  = '0;
            ewords_d = '0;
        end else begin
            if (rx_valid) begin
                hist_d = chk_nxt;
                if (!lock_q) begin
                    if (mis != '0) good_d = '0;
                    else if (good_q == GW'(LOCK_WORDS - 1)) begin
                        lock_d = 1'b1;
                        good_d = '0;
                        bad_d  = '0;
                    end else good_d = good_q + 1'b1;
                end else begin
                    ebits_d = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
                    if (mis != '0) begin
                        ewords_d = wsum[CNT_W] ? '1 : wsum[CNT_W-1:0];
                        if (bad_q == BW'(LOSS_WORDS - 1)) begin
                            lock_d = 1'b0;
                            bad_d  = '0;
                            good_d = '0;
                        end else bad_d = bad_q + 1'b1;
                    end else bad_d = '0;
                end
            end
            if (clr_cnt) begin
                ebits_d  = '0;
                ewords_d = '0;
            end
        end
    end

    // Checker state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hist_q   <= '1;
            mprev_q  <= 2'd0;
            good_q   <= '0;
            bad_q    <= '0;
            lock_q   <= 1'b0;
            ebits_q  <= '0;
            ewords_q <= '0;
        end else begin
            hist_q   <= hist_d;
            mprev_q  <= mprev_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            lock_q   <= lock_d;
            ebits_q  <= ebits_d;
            ewords_q <= ewords_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_locked = lock_q;
    assign err_bits  = ebits_q;
    assign err_words = ewords_q;

endmodule

// File: tb/tb_prbs_word_engine.sv
// Scoreboard bench for prbs_word_engine: stimulus pushes expected words, a
// negedge monitor pops and compares on every tx handshake.
module tb_prbs_word_engine;
    localparam int DW = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          start, stop, inj, tx_ready, clr;
    logic [15:0]   burst;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, busy, done, rx_valid, rx_locked;
    logic [CW-1:0] err_bits, err_words;
    logic          loop_en, force_zero;

    assign rx_data  = force_zero ? '0 : tx_data;
    assign rx_valid = loop_en & tx_valid & tx_ready;

    prbs_word_engine #(.DATA_W(DW), .LOCK_WORDS(4), .LOSS_WORDS(4), .CNT_W(CW)) dut (
        .CLOCK_50(clk), .reset(rst), .mode(mode), .start(start), .stop(stop),
        .burst_words(burst), .inject_err(inj), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .rx_data(rx_data),
        .rx_valid(rx_valid), .clr_cnt(clr), .rx_locked(rx_locked),
        .err_bits(err_bits), .err_words(err_words)
    );

    always #10 clk = ~clk;

    int            tests = 0, fails = 0;
    logic [DW-1:0] exp_q[$];
    logic          mon_en = 1'b0;
    int            hs_cnt = 0, hs_all = 0;
    logic [DW-1:0] cap[0:299];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bit-serial reference: b[n] = b[n-L] ^ b[n-T], first L bits all ones.
    function automatic logic [DW-1:0] model_word(input logic [1:0] m, input int idx);
        logic b[0:4095];
        logic [DW-1:0] w;
        int L, T;
        case (m)
            2'd0:    begin L = 7;  T = 6;  end
            2'd1:    begin L = 11; T = 9;  end
            2'd2:    begin L = 15; T = 14; end
            default: begin L = 31; T = 28; end
        endcase
        for (int n = 0; n < (idx + 1) * DW; n++)
            b[n] = (n < L) ? 1'b1 : (b[n-L] ^ b[n-T]);
        for (int i = 0; i < DW; i++) w[i] = b[idx*DW + i];
        return w;
    endfunction

    task automatic push_model(input logic [1:0] m, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(model_word(m, k));
    endtask

    // Monitor: scoreboard pop on handshake, hold check while stalled.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data, e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) hs_all++;
            if (!rst && mon_en) begin
                if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %0h with empty scoreboard", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_word", tx_data, e);
                    end
                    if (hs_cnt < 300) cap[hs_cnt] = tx_data;
                    hs_cnt++;
                end
                prev_stall = tx_valid & ~tx_ready;
                prev_data  = tx_data;
            end else prev_stall = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        logic got;
        got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk(nm, got, 1'b1);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_valid"}, tx_valid, 1'b0);
    endtask

    task automatic wait_lock(input string nm, input int maxc);
        logic got;
        got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            @(negedge clk);
            if (rx_locked) got = 1'b1;
        end
        chk(nm, got, 1'b1);
    endtask

    initial begin
        int base, idx, ebits_exp, wlock;
        logic [DW-1:0] w;
        logic dseen;
        rst = 1'b1; mode = 2'd0; start = 1'b0; stop = 1'b0; inj = 1'b0; clr = 1'b0;
        burst = 16'd0; tx_ready = 1'b0; loop_en = 1'b0; force_zero = 1'b0;
        repeat (2) tick();
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_locked", rx_locked, 1'b0);
        chk("rst_err_bits", err_bits, 32'd0);
        chk("rst_err_words", err_words, 32'd0);
        rst = 1'b0;
        tick();

        // PRBS7 burst of two words: hand-computed 0x7F then 0x20.
        tx_ready = 1'b1; burst = 16'd2; hs_cnt = 0;
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h20);
        mon_en = 1'b1;
        pulse_start();
        wait_done("burst2_done", 10);
        chk("burst2_count", hs_cnt, 2);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        mon_en = 1'b0;

        // start and stop together while idle: nothing starts.
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("start_stop_idle_busy", busy, 1'b0);
        chk("start_stop_idle_valid", tx_valid, 1'b0);

        // Continuous PRBS7 with tx_ready toggling; period of 127 words.
        exp_q.delete();
        push_model(2'd0, 300);
        burst = 16'd0; hs_cnt = 0; tx_ready = 1'b1; mon_en = 1'b1;
        tick();
        pulse_start();
        for (int k = 0; k < 1000 && hs_cnt < 260; k++) begin
            tick();
            tx_ready = ~tx_ready;
        end
        tx_ready = 1'b0; mon_en = 1'b0;
        chk("stall_run_reached", hs_cnt >= 260, 1'b1);
        chk("period127_word128", cap[127], 8'h7F);
        chk("period127_word129", cap[128], 8'h20);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("stop_done", done, 1'b1);
        chk("stop_busy", busy, 1'b0);
        exp_q.delete();

        // Other polynomials, mode port changed mid-burst must not disturb tx.
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m); burst = 16'd20; tx_ready = 1'b1; hs_cnt = 0;
            push_model(2'(m), 20);
            mon_en = 1'b1;
            tick();
            pulse_start();
            repeat (3) tick();
            mode = 2'(m) ^ 2'b01;
            wait_done($sformatf("mode%0d_done", m), 40);
            chk($sformatf("mode%0d_count", m), hs_cnt, 20);
            chk($sformatf("mode%0d_sb_empty", m), exp_q.size(), 0);
            mon_en = 1'b0;
            exp_q.delete();
        end

        // Loopback, all modes; PRBS7 last and left running.
        loop_en = 1'b1; tx_ready = 1'b1; burst = 16'd0;
        for (int j = 0; j < 4; j++) begin
            mode = 2'((j + 1) % 4);
            tick();
            clr = 1'b1;
            tick();
            clr = 1'b0;
            pulse_start();
            base = hs_all;
            wait_lock($sformatf("lock_mode%0d", mode), 40);
            wlock = hs_all - base;
            chk($sformatf("lock_min_words_mode%0d", mode), wlock >= 4, 1'b1);
            repeat ((mode == 2'd0) ? 10000 : 3000) tick();
            chk($sformatf("loop_err_bits_mode%0d", mode), err_bits, 32'd0);
            chk($sformatf("loop_err_words_mode%0d", mode), err_words, 32'd0);
            chk($sformatf("loop_locked_mode%0d", mode), rx_locked, 1'b1);
            if (mode != 2'd0) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                repeat (2) tick();
            end
        end

        // Single injected bit error while locked.
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (6) tick();
        chk("inject_err_bits", err_bits, 32'd1);
        chk("inject_err_words", err_words, 32'd1);
        chk("inject_locked", rx_locked, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err_bits", err_bits, 32'd0);
        chk("clr_err_words", err_words, 32'd0);

        // Four all-zero words drop lock; errors counted from the reference sequence.
        idx = hs_all - base;
        ebits_exp = 0;
        for (int k = 0; k < 4; k++) begin
            w = model_word(2'd0, (idx + k) % 127);
            for (int i = 0; i < DW; i++) ebits_exp += int'(w[i]);
        end
        force_zero = 1'b1;
        repeat (4) tick();
        chk("zero_unlock", rx_locked, 1'b0);
        force_zero = 1'b0;
        chk("zero_err_words", err_words, 32'd4);
        chk("zero_err_bits", err_bits, 32'(ebits_exp));
        wait_lock("relock", 20);
        chk("frozen_err_words", err_words, 32'd4);
        chk("frozen_err_bits", err_bits, 32'(ebits_exp));

        // Asynchronous reset mid-burst, away from a clock edge.
        tick();
        #4;
        rst = 1'b1;
        #1;
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_locked", rx_locked, 1'b0);
        chk("arst_err_bits", err_bits, 32'd0);
        chk("arst_err_words", err_words, 32'd0);
        chk("arst_tx_data", tx_data, 8'h00);
        dseen = 1'b0;
        loop_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dseen |= done;
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dseen |= done;
        end
        chk("arst_no_done", dseen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
